// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window controller.
package conv_pkg;

  // Kernel edge length of the line-buffer window generator.
  localparam int KERNEL = 5;

  // Controller phases for one frame.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } conv_ctrl_state_t;

  // Bits needed to hold indices 0..n-1.
  // Never returns zero, so a degenerate dimension still gets a legal 1-bit vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_ctrl_raster_counter.sv
// Raster position tracker: column/row counters that step on each accepted pixel.
// The column wraps at W-1 and bumps the row.
// The last pixel of the frame returns both counters to zero, ready for the next frame.
module raster_counter
  import conv_pkg::*;
#(
  parameter int W = 32,
  parameter int H = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [cnt_width(W)-1:0] col,
  output logic [cnt_width(H)-1:0] row,
  output logic                    last
);

  localparam int CW = cnt_width(W);
  localparam int RW = cnt_width(H);

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic          col_wrap;

  assign col_wrap = (col_reg == COL_MAX);
  assign last     = col_wrap && (row_reg == ROW_MAX);
  assign col      = col_reg;
  assign row      = row_reg;

  // Advance the raster position on each enabled cycle; wrap column and frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_MAX) ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for a KxK line-buffer window generator.
// It accepts a raster pixel stream and forwards each accepted pixel to the line buffer as a shift.
// It flags only windows lying fully inside the frame, with their output-map coordinates.
// A pending window blocks further shifts until downstream takes it, so the buffer never moves under an unconsumed window.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = KERNEL
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              s_valid,
  input  logic [7:0]                        s_pixel,
  output logic                              s_ready,
  output logic                              lb_valid,
  output logic [7:0]                        lb_pixel,
  output logic                              win_valid,
  output logic [cnt_width(IMG_H-K+1)-1:0]   win_row,
  output logic [cnt_width(IMG_W-K+1)-1:0]   win_col,
  input  logic                              m_ready,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int CW  = cnt_width(IMG_W);
  localparam int RW  = cnt_width(IMG_H);
  localparam int WCW = cnt_width(IMG_W - K + 1);
  localparam int WRW = cnt_width(IMG_H - K + 1);

  // First raster column/row at which the KxK buffer holds a real in-frame window.
  localparam logic [CW-1:0] WARM_COL = CW'(K - 1);
  localparam logic [RW-1:0] WARM_ROW = RW'(K - 1);

  conv_ctrl_state_t state_reg;
  conv_ctrl_state_t state_next;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           last_pixel;
  logic           accept;
  logic           window_ready;

  logic           win_valid_reg;
  logic [WRW-1:0] win_row_reg;
  logic [WCW-1:0] win_col_reg;

  // ---------------------------------------------------------------------------
  // Handshake
  // A new pixel may be accepted while streaming, provided the current window is absent or leaving this cycle.
  // That lets accept and consume overlap for 1 pixel/clk.
  // ---------------------------------------------------------------------------
  assign s_ready  = (state_reg == STREAM) && (!win_valid_reg || m_ready);
  assign accept   = s_valid && s_ready;
  assign lb_valid = accept;
  assign lb_pixel = s_pixel;

  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == DONE);

  // Pixel just shifted in completes a window only once K-1 rows and K-1 columns of that row are behind it.
  // This masks the warm-up rows and the row-wrap columns that still hold stale data.
  assign window_ready = accept && (row >= WARM_ROW) && (col >= WARM_COL);

  raster_counter #(
    .W (IMG_W),
    .H (IMG_H)
  ) u_raster (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .col  (col),
    .row  (row),
    .last (last_pixel)
  );

  // ---------------------------------------------------------------------------
  // Frame sequencing
  // ---------------------------------------------------------------------------

  // Next-state decode: stream until the final pixel, then drain the last window.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (accept && last_pixel) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (win_valid_reg && m_ready) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Window flag and coordinates
  // The line buffer is registered, so the window for a pixel accepted now is presented next cycle.
  // A new window replaces a consumed one with no bubble.
  // An unconsumed window holds together with its coordinates.
  // ---------------------------------------------------------------------------

  // Window present/consumed tracking with output-map coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_reg <= 1'b0;
      win_row_reg   <= '0;
      win_col_reg   <= '0;
    end else if (window_ready) begin
      win_valid_reg <= 1'b1;
      win_row_reg   <= WRW'(row - WARM_ROW);
      win_col_reg   <= WCW'(col - WARM_COL);
    end else if (m_ready) begin
      win_valid_reg <= 1'b0;
    end
  end

  assign win_valid = win_valid_reg;
  assign win_row   = win_row_reg;
  assign win_col   = win_col_reg;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl on an 8x8 frame with a 5x5 kernel.
// A behavioural model predicts the handshake and window timing from pixel counts.
// The model pushes each expected window (coordinates + golden pixels) into a scoreboard.
// A monitor pops and compares whenever the controller presents a window.
module tb_conv_window_ctrl;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int K    = 5;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - K + 1) * (H - K + 1);
  localparam int LBN  = (K - 1) * W + K;

  localparam int M_IDLE   = 0;
  localparam int M_STREAM = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_DONE   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_pixel = 8'd0;
  logic       m_ready = 1'b1;
  logic       s_ready;
  logic       lb_valid;
  logic [7:0] lb_pixel;
  logic       win_valid;
  logic [1:0] win_row;
  logic [1:0] win_col;
  logic       busy;
  logic       frame_done;

  conv_window_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .K     (K)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_pixel    (s_pixel),
    .s_ready    (s_ready),
    .lb_valid   (lb_valid),
    .lb_pixel   (lb_pixel),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .m_ready    (m_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]         r;
    logic [7:0]         c;
    logic [8*K*K-1:0]   w;
  } win_t;

  win_t       exp_q[$];
  logic [7:0] frm [NPIX];
  logic [7:0] lbm [LBN];

  int n_checks  = 0;
  int n_pass    = 0;
  int n_windows = 0;

  // reference model state
  int mode    = M_IDLE;
  int count   = 0;
  bit pending = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [8*K*K-1:0] golden(input int r0, input int c0);
    logic [8*K*K-1:0] w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*8 +: 8] = frm[(r0+i)*W + (c0+j)];
    return w;
  endfunction

  // Line buffer the parent would own: shifts on every lb_valid.
  always @(posedge clk) begin
    if (lb_valid === 1'b1) begin
      for (int i = LBN - 1; i > 0; i--) lbm[i] <= lbm[i-1];
      lbm[0] <= lb_pixel;
    end
  end

  // Reference model: predicts handshake, flags and the expected window stream.
  always begin
    bit     exp_ready;
    bit     acc;
    bit     produced;
    int     r;
    int     c;
    win_t   e;
    @(negedge clk);
    #1;
    exp_ready = (mode == M_STREAM) && (!pending || m_ready);
    acc       = s_valid && exp_ready;
    chk("s_ready",    32'(s_ready),    32'(exp_ready));
    chk("lb_valid",   32'(lb_valid),   32'(acc));
    chk("win_valid",  32'(win_valid),  32'(pending));
    chk("busy",       32'(busy),       32'(mode != M_IDLE));
    chk("frame_done", 32'(frame_done), 32'(mode == M_DONE));
    if (acc) chk("lb_pixel", 32'(lb_pixel), 32'(s_pixel));
    if (rst) begin
      mode    = M_IDLE;
      count   = 0;
      pending = 1'b0;
      exp_q.delete();
    end else begin
      produced = 1'b0;
      case (mode)
        M_IDLE: if (start) begin mode = M_STREAM; count = 0; end
        M_STREAM: if (acc) begin
          r = count / W;
          c = count % W;
          if (r >= K - 1 && c >= K - 1) begin
            e.r = 8'(r - (K - 1));
            e.c = 8'(c - (K - 1));
            e.w = golden(r - (K - 1), c - (K - 1));
            exp_q.push_back(e);
            produced = 1'b1;
          end
          count++;
          if (count == NPIX) mode = M_DRAIN;
        end
        M_DRAIN: if (pending && m_ready) mode = M_DONE;
        default: mode = M_IDLE;
      endcase
      if (produced) pending = 1'b1;
      else if (m_ready) pending = 1'b0;
    end
  end

  // Monitor: compares every presented window against the scoreboard head.
  always begin
    win_t             e;
    logic [8*K*K-1:0] got;
    @(negedge clk);
    if (win_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL win_unexpected: got window r=%0d c=%0d expected none at %0t", win_row, win_col, $time);
      end else begin
        e = exp_q[0];
        chk("win_row", 32'(win_row), 32'(e.r));
        chk("win_col", 32'(win_col), 32'(e.c));
        if (m_ready === 1'b1) begin
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              got[(i*K+j)*8 +: 8] = lbm[(K-1-i)*W + (K-1-j)];
          n_checks++;
          if (got === e.w) n_pass++;
          else $display("FAIL win_data r=%0d c=%0d: got %h expected %h", e.r, e.c, got, e.w);
          void'(exp_q.pop_front());
          n_windows++;
          $display("window r=%0d c=%0d consumed at %0t", e.r, e.c, $time);
        end
      end
    end
  end

  task automatic fill_frame();
    for (int i = 0; i < NPIX; i++) frm[i] = 8'($urandom);
  endtask

  task automatic start_frame();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  // Drive up to n pixels of frm with optional gaps, random m_ready, a 5-cycle stall after pixel stall_at,
  // and a stray start pulse at start_at. With abort=1, reset is asserted right after the last pixel.
  task automatic send_pixels(input int n, input int gap, input int mr_pct,
                             input int stall_at, input int start_at, input bit abort);
    int idx   = 0;
    int stall = 0;
    int cyc   = 0;
    bit stalled;
    while (idx < n && cyc < 3000) begin
      @(posedge clk); #1;
      stalled = (stall > 0);
      s_valid = ($urandom_range(99) >= gap);
      s_pixel = s_valid ? frm[idx] : 8'($urandom);
      if (stalled) begin
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_pixel = frm[idx];
        stall--;
      end else begin
        m_ready = ($urandom_range(99) < mr_pct);
      end
      start = (idx == start_at);
      @(negedge clk);
      if (stalled) begin
        chk("stall_s_ready",  32'(s_ready),  32'(0));
        chk("stall_lb_valid", 32'(lb_valid), 32'(0));
        chk("stall_win_row",  32'(win_row),  32'(1));
        chk("stall_win_col",  32'(win_col),  32'(2));
      end
      if (s_valid && s_ready) begin
        if (idx == stall_at) stall = 5;
        idx++;
      end
      cyc++;
    end
    if (cyc >= 3000) begin
      n_checks++;
      $display("FAIL stream_timeout: got %0d pixels expected %0d", idx, n);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    start   = 1'b0;
    if (abort) begin
      rst     = 1'b1;
      m_ready = 1'b0;
      @(posedge clk); #1;
      rst     = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      chk("rst_win_valid", 32'(win_valid), 32'(0));
      chk("rst_busy",      32'(busy),      32'(0));
    end else begin
      m_ready = 1'b1;
    end
  endtask

  task automatic wait_done(input int base);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    chk("frame_done_seen", 32'(seen), 32'(1));
    chk("window_count", 32'(n_windows - base), 32'(NWIN));
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_win_row", 32'(win_row), 32'(0));
    chk("reset_win_col", 32'(win_col), 32'(0));
    chk("reset_s_ready", 32'(s_ready), 32'(0));
    @(posedge clk); #1; rst = 1'b0;

    // s_valid while idle must be ignored
    repeat (3) begin
      @(posedge clk); #1; s_valid = 1'b1; s_pixel = 8'($urandom);
    end
    @(posedge clk); #1; s_valid = 1'b0;

    // back-to-back frame at full throughput
    fill_frame(); base = n_windows;
    start_frame();
    send_pixels(NPIX, 0, 100, -1, -1, 1'b0);
    wait_done(base);

    // stall at window (1,2) plus a stray start mid-stream
    fill_frame(); base = n_windows;
    start_frame();
    send_pixels(NPIX, 0, 100, 46, 20, 1'b0);
    wait_done(base);

    // random input gaps and random downstream readiness
    repeat (2) begin
      fill_frame(); base = n_windows;
      start_frame();
      send_pixels(NPIX, 50, 70, -1, -1, 1'b0);
      wait_done(base);
    end

    // reset mid-frame after 40 pixels, then a clean frame
    fill_frame();
    start_frame();
    send_pixels(40, 0, 100, -1, -1, 1'b1);
    fill_frame(); base = n_windows;
    start_frame();
    send_pixels(NPIX, 20, 100, -1, -1, 1'b0);
    wait_done(base);

    // second frame started the cycle after frame_done
    fill_frame(); base = n_windows;
    start_frame();
    send_pixels(NPIX, 0, 100, -1, -1, 1'b0);
    wait_done(base);

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
